// File: rtl/seq_addsub_acc.sv
// seq_addsub_acc: bit-serial N-bit add/subtract accumulator with a synchronised go request,
// a busy/done handshake, carry and overflow flags, and a saturating operation counter.
`default_nettype none

module seq_addsub_acc #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         go,
  input  logic [1:0]   op,
  input  logic [N-1:0] B,
  output logic [N-1:0] ACC,
  output logic         cout,
  output logic         ovf,
  output logic         busy,
  output logic         done,
  output logic [7:0]   nops
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   start;

  logic           sub_r;
  logic [N-1:0]   a_sh, b_sh, res;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic           bb, sum_bit, carry_nx, last;
  logic [N-1:0]   res_nx;

  // go is asynchronous: only the last synchroniser stage feeds the edge detector.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      start  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], go};
      edge_q <= sync_q[SYNC_STAGES-1];
      start  <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (op == 2'b01 || op == 2'b10) ? SHIFT : DONE;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert each B bit and seed the carry with 1.
  always_comb begin
    bb       = b_sh[0] ^ sub_r;
    sum_bit  = a_sh[0] ^ bb ^ carry;
    carry_nx = (a_sh[0] & bb) | (a_sh[0] & carry) | (bb & carry);
    res_nx   = {sum_bit, res[N-1:1]};
    last     = (cnt == CW'(N - 1));
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sub_r <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      ACC   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      nops  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sub_r <= op[1];
            b_sh  <= B;
            a_sh  <= ACC;
            cnt   <= '0;
            carry <= op[1];
            if (op == 2'b00) begin
              ACC  <= B;
              cout <= 1'b0;
              ovf  <= 1'b0;
            end else if (op == 2'b11) begin
              ACC  <= '0;
              cout <= 1'b0;
              ovf  <= 1'b0;
              nops <= 8'd0;
            end
          end
        end
        SHIFT: begin
          res   <= res_nx;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_nx;
          cnt   <= cnt + CW'(1);
          // On the MSB cycle, carry still holds the carry into the MSB.
          if (last) begin
            ACC  <= res_nx;
            cout <= carry_nx;
            ovf  <= carry ^ carry_nx;
            if (nops != 8'hFF) nops <= nops + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_addsub_acc.sv
// tb_seq_addsub_acc: directed vectors, expected results queued at issue and checked on each done pulse.
`default_nettype none

module tb_seq_addsub_acc;
  localparam int N  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         go;
  logic [1:0]   op;
  logic [N-1:0] B;
  logic [N-1:0] ACC;
  logic         cout, ovf, busy, done;
  logic [7:0]   nops;

  seq_addsub_acc #(.N(N), .SYNC_STAGES(SS)) dut (
    .CLOCK_50(clk), .reset(reset), .go(go), .op(op), .B(B),
    .ACC(ACC), .cout(cout), .ovf(ovf), .busy(busy), .done(done), .nops(nops)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] acc;
    logic       c;
    logic       v;
    logic [7:0] n;
    int         busy_n;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: counts busy cycles and checks every done pulse against the queue head.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        chk("done_busy_excl", int'(busy), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("acc",        int'(ACC),  int'(e.acc));
          chk("cout",       int'(cout), int'(e.c));
          chk("ovf",        int'(ovf),  int'(e.v));
          chk("nops",       int'(nops), int'(e.n));
          chk("busy_cycles", busy_cnt,  e.busy_n);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic push(input logic [1:0] o, input logic [7:0] ea, input logic ec,
                      input logic ev, input logic [7:0] en);
    exp_t e;
    e.acc = ea; e.c = ec; e.v = ev; e.n = en;
    e.busy_n = (o == 2'b01 || o == 2'b10) ? N : 0;
    exp_q.push_back(e);
  endtask

  task automatic pulse_go(input logic [1:0] o, input logic [7:0] b);
    @(negedge clk);
    op = o; B = b; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    if (!got) chk("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [7:0] b, input logic [7:0] ea,
                       input logic ec, input logic ev, input logic [7:0] en);
    push(o, ea, ec, ev, en);
    pulse_go(o, b);
    wait_done();
  endtask

  task automatic wait_busy(input int k);
    int seen = 0;
    for (int i = 0; i < 40 && seen < k; i++) begin
      @(negedge clk);
      if (busy) seen++;
    end
    if (seen < k) chk("busy_timeout", seen, k);
  endtask

  initial begin
    int lat;
    reset = 1'b1; go = 1'b1; op = 2'b00; B = 8'h5A;

    // 1: reset with go held high; one load executes after release
    repeat (3) @(negedge clk);
    chk("rst_acc",  int'(ACC),  0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_ovf",  int'(ovf),  0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_nops", int'(nops), 0);
    push(2'b00, 8'h5A, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clk);
      if (done) lat = k;
    end
    chk("t1_latency", lat, SS + 2);
    repeat (20) @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);

    // 2
    do_op(2'b00, 8'h3C, 8'h3C, 1'b0, 1'b0, 8'd0);
    do_op(2'b01, 8'h05, 8'h41, 1'b0, 1'b0, 8'd1);
    // 3
    do_op(2'b00, 8'h7F, 8'h7F, 1'b0, 1'b0, 8'd1);
    do_op(2'b01, 8'h01, 8'h80, 1'b0, 1'b1, 8'd2);
    do_op(2'b00, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'd2);
    do_op(2'b01, 8'h01, 8'h00, 1'b1, 1'b0, 8'd3);
    // 4
    do_op(2'b00, 8'h05, 8'h05, 1'b0, 1'b0, 8'd3);
    do_op(2'b10, 8'h07, 8'hFE, 1'b0, 1'b0, 8'd4);
    do_op(2'b00, 8'h80, 8'h80, 1'b0, 1'b0, 8'd4);
    do_op(2'b10, 8'h01, 8'h7F, 1'b1, 1'b1, 8'd5);

    // 5: a clear requested mid-add is dropped
    do_op(2'b00, 8'h10, 8'h10, 1'b0, 1'b0, 8'd5);
    push(2'b01, 8'h11, 1'b0, 1'b0, 8'd6);
    pulse_go(2'b01, 8'h01);
    wait_busy(3);
    op = 2'b11; B = 8'h00; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    chk("t5_acc_kept", int'(ACC), 8'h11);

    // 5b: reset during an add aborts it
    pulse_go(2'b01, 8'h01);
    wait_busy(4);
    reset = 1'b1;
    #1;
    chk("abort_acc",  int'(ACC),  0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_nops", int'(nops), 0);
    chk("abort_cout", int'(cout), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done_acc", int'(ACC), 0);

    // 6: 260 adds from 0, counter saturates, then clear
    do_op(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 260; i++) begin
      logic [7:0] ea, en;
      ea = 8'(i % 256);
      en = (i > 255) ? 8'd255 : 8'(i);
      do_op(2'b01, 8'h01, ea, (i == 256), (i == 128), en);
    end
    do_op(2'b11, 8'hAA, 8'h00, 1'b0, 1'b0, 8'd0);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
